// File: rtl/key_press_classifier.sv
// Key press classifier. It takes a debounced key level and produces three
// one-cycle events (short press, long press, auto-repeat) plus a held flag.
module key_press_classifier #(
  parameter logic        KEY_ACTIVE  = 1'b0,
  parameter int unsigned LONG_TIME   = 50_000_000,
  parameter int unsigned REPEAT_TIME = 10_000_000,
  parameter bit          REPEAT_EN   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic key_held
);

  // state | meaning
  // IDLE  | key released, waiting for a press
  // PRESS | key held, counting toward the long-press threshold
  // LONG  | long press reported, counting auto-repeat intervals
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [31:0] LONG_LAST   = 32'(LONG_TIME - 1);
  localparam logic [31:0] REPEAT_LAST = 32'(REPEAT_TIME - 1);

  state_t      state;
  logic [31:0] cnt;
  logic        pressed;

  assign pressed = (key_in == KEY_ACTIVE);

  // Release is tested first in every state so it wins over a threshold hit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      short_pulse  <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            state    <= PRESS;
            cnt      <= '0;
            key_held <= 1'b1;
          end
        end
        PRESS: begin
          if (!pressed) begin
            state       <= IDLE;
            cnt         <= '0;
            short_pulse <= 1'b1;
            key_held    <= 1'b0;
          end else if (cnt == LONG_LAST) begin
            state      <= LONG;
            cnt        <= '0;
            long_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        LONG: begin
          if (!pressed) begin
            state    <= IDLE;
            cnt      <= '0;
            key_held <= 1'b0;
          end else if (cnt == REPEAT_LAST) begin
            if (REPEAT_EN) begin
              cnt          <= '0;
              repeat_pulse <= 1'b1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state    <= IDLE;
          cnt      <= '0;
          key_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_press_classifier.sv
// Bench for key_press_classifier: two instances (auto-repeat on and off) driven
// by the same key stream and compared every cycle against a hold-age model.
module tb_key_press_classifier;

  localparam int LT = 10;
  localparam int RT = 4;

  logic clk = 1'b0;
  logic rst;
  logic key_in;
  logic sp [2];
  logic lp [2];
  logic rp [2];
  logic kh [2];

  always #5 clk = ~clk;

  key_press_classifier #(
    .KEY_ACTIVE(1'b0), .LONG_TIME(LT), .REPEAT_TIME(RT), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in),
    .short_pulse(sp[0]), .long_pulse(lp[0]), .repeat_pulse(rp[0]), .key_held(kh[0])
  );

  key_press_classifier #(
    .KEY_ACTIVE(1'b0), .LONG_TIME(LT), .REPEAT_TIME(RT), .REPEAT_EN(1'b0)
  ) dut_nr (
    .clk(clk), .rst(rst), .key_in(key_in),
    .short_pulse(sp[1]), .long_pulse(lp[1]), .repeat_pulse(rp[1]), .key_held(kh[1])
  );

  int errors = 0;
  int checks = 0;

  // Model: age = edges since the press began (-1 when released).
  int age [2];
  bit e_sp [2];
  bit e_lp [2];
  bit e_rp [2];
  bit e_kh [2];

  int n_sp [2];
  int n_lp [2];
  int n_rp [2];
  int n_kh [2];

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    for (int i = 0; i < 2; i++) begin
      n_sp[i] = 0; n_lp[i] = 0; n_rp[i] = 0; n_kh[i] = 0;
    end
  endtask

  task automatic step(input bit press, input bit r);
    key_in = press ? 1'b0 : 1'b1;
    rst    = r;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      e_sp[i] = 1'b0; e_lp[i] = 1'b0; e_rp[i] = 1'b0;
      if (r) begin
        age[i]  = -1;
        e_kh[i] = 1'b0;
      end else if (age[i] < 0) begin
        if (press) begin
          age[i]  = 0;
          e_kh[i] = 1'b1;
        end
      end else if (!press) begin
        e_sp[i] = (age[i] < LT);
        age[i]  = -1;
        e_kh[i] = 1'b0;
      end else begin
        age[i]++;
        e_lp[i] = (age[i] == LT);
        e_rp[i] = (i == 0) && (age[i] > LT) && (((age[i] - LT) % RT) == 0);
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("short_pulse[%0d]", i),  sp[i], e_sp[i]);
      check($sformatf("long_pulse[%0d]", i),   lp[i], e_lp[i]);
      check($sformatf("repeat_pulse[%0d]", i), rp[i], e_rp[i]);
      check($sformatf("key_held[%0d]", i),     kh[i], e_kh[i]);
      n_sp[i] += int'(sp[i]); n_lp[i] += int'(lp[i]);
      n_rp[i] += int'(rp[i]); n_kh[i] += int'(kh[i]);
    end
  endtask

  task automatic hold(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0);
  endtask

  initial begin
    int long_at;
    key_in = 1'b1;
    rst    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      age[i] = -1; e_kh[i] = 1'b0;
    end

    // Reset with key released
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    idle(2);

    // Short press: 5 cycles held, then release
    clear_counts();
    hold(5);
    idle(3);
    check_int("short5_short_cnt", n_sp[0], 1);
    check_int("short5_long_cnt", n_lp[0], 0);

    // Long press with auto-repeat: 20 cycles held
    clear_counts();
    hold(20);
    idle(3);
    check_int("long20_long_cnt", n_lp[0], 1);
    check_int("long20_repeat_cnt", n_rp[0], 2);
    check_int("long20_short_cnt", n_sp[0], 0);
    check_int("long20_nr_repeat_cnt", n_rp[1], 0);

    // Release exactly at the long threshold count
    clear_counts();
    hold(LT);
    idle(3);
    check_int("edge_short_cnt", n_sp[0], 1);
    check_int("edge_long_cnt", n_lp[0], 0);

    // Repeat disabled: 30 cycles held
    clear_counts();
    hold(30);
    idle(3);
    check_int("norep_long_cnt", n_lp[1], 1);
    check_int("norep_repeat_cnt", n_rp[1], 0);
    check_int("rep_repeat_cnt", n_rp[0], 4);

    // Reset mid-press at count 6 with key held
    clear_counts();
    hold(7);
    step(1'b1, 1'b1);
    check_int("rst_mid_no_pulse", n_sp[0] + n_lp[0] + n_rp[0], 0);
    long_at = -1;
    for (int k = 1; k <= 15; k++) begin
      step(1'b1, 1'b0);
      if (lp[0] === 1'b1 && long_at < 0) long_at = k;
    end
    // Edge 1 re-enters PRESS; long shows after edge 11, ten edges later
    check_int("rst_long_delay", long_at - 1, LT);
    idle(3);

    // One-cycle glitch
    clear_counts();
    hold(1);
    idle(3);
    check_int("glitch_short_cnt", n_sp[0], 1);
    check_int("glitch_held_cycles", n_kh[0], 1);

    // Random hold/release bursts with occasional reset
    for (int b = 0; b < 60; b++) begin
      int h;
      int g;
      h = int'($urandom_range(1, 26));
      g = int'($urandom_range(1, 4));
      for (int k = 0; k < h; k++) step(1'b1, ($urandom_range(0, 31) == 0));
      for (int k = 0; k < g; k++) step(1'b0, ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
